// File: rtl/serial_deser.sv
// Serial-in/parallel-out word receiver with a sync-marker framer.
// Completed words go into a holding register that the consumer reads with a full/rd handshake.
module serial_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             n_clr,
    input  logic             shift_en,
    input  logic             sync,
    input  logic             din,
    input  logic             rd,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             valid,
    output logic             busy,
    output logic             ovr,
    output logic             ferr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0] sr, sr_nx, sr_shift;
    logic            complete, frame_err, accept, drop;

    assign sr_shift = MSB_FIRST ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        sr_nx     = sr;
        complete  = 1'b0;
        frame_err = 1'b0;
        if (shift_en) begin
            case (state)
                IDLE: begin
                    if (sync) begin
                        sr_nx    = sr_shift;
                        cnt_nx   = ONE;
                        state_nx = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_nx = sr_shift;
                    if (sync) begin
                        // A marker mid-word aborts the fragment; the marker bit starts a fresh word.
                        frame_err = (cnt != '0);
                        cnt_nx    = ONE;
                    end else if (cnt == LAST) begin
                        complete = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign accept = complete & (~full | rd);
    assign drop   = complete & full & ~rd;
    assign busy   = (state == SHIFT) && (cnt != '0);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            dout  <= '0;
            full  <= 1'b0;
            valid <= 1'b0;
            ovr   <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            sr    <= sr_nx;
            valid <= accept;
            if (accept) begin
                dout <= sr_shift;
                full <= 1'b1;
            end else if (rd) begin
                full <= 1'b0;
            end
            // Set events take priority over clr_err on the same edge.
            ovr  <= drop | (ovr & ~clr_err);
            ferr <= frame_err | (ferr & ~clr_err);
        end
    end

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser: table of stream words plus hand-written framing,
// overrun, reset and bit-order sequences. Two instances share inputs (MSB- and LSB-first).
module tb_serial_deser;

    logic       clk = 1'b0;
    logic       n_clr, shift_en, sync, din, rd, clr_err;
    logic [7:0] dout, dout_lsb;
    logic       full, valid, busy, ovr, ferr;
    logic       full_lsb, valid_lsb, busy_lsb, ovr_lsb, ferr_lsb;

    int n_vec = 0;
    int n_bad = 0;
    int vcnt  = 0;

    serial_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .n_clr(n_clr), .shift_en(shift_en), .sync(sync), .din(din),
        .rd(rd), .clr_err(clr_err), .dout(dout), .full(full), .valid(valid),
        .busy(busy), .ovr(ovr), .ferr(ferr)
    );

    serial_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .n_clr(n_clr), .shift_en(shift_en), .sync(sync), .din(din),
        .rd(rd), .clr_err(clr_err), .dout(dout_lsb), .full(full_lsb), .valid(valid_lsb),
        .busy(busy_lsb), .ovr(ovr_lsb), .ferr(ferr_lsb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (valid) vcnt++;

    typedef struct {
        logic [7:0] word;
        logic       sync_first;
        logic       rd_first;
        logic       rd_last;
        logic       clr_first;
        logic [7:0] exp_dout;
        logic       exp_full;
        logic       exp_valid;
        logic       exp_ovr;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s, input logic r, input logic c);
        shift_en = 1'b1; din = b; sync = s; rd = r; clr_err = c;
        tick();
        shift_en = 1'b0; din = 1'b0; sync = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic s, input logic rf,
                             input logic rl, input logic cf);
        for (int i = 7; i >= 0; i--)
            send_bit(w[i], (i == 7) && s, ((i == 7) && rf) || ((i == 0) && rl), (i == 7) && cf);
    endtask

    initial begin
        logic [7:0] w;

        tbl[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0};

        n_clr = 1'b0; shift_en = 1'b0; sync = 1'b0; din = 1'b0; rd = 1'b0; clr_err = 1'b0;
        #12;
        check("reset dout", dout, 8'h00);
        check("reset full", full, 1'b0);
        check("reset valid", valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset ovr", ovr, 1'b0);
        check("reset ferr", ferr, 1'b0);
        n_clr = 1'b1;
        tick();

        // Sparse strobes, one bit every 4 clocks
        w = 8'hA5;
        for (int i = 7; i >= 1; i--) begin
            send_bit(w[i], i == 7, 1'b0, 1'b0);
            repeat (3) tick();
        end
        check("a5 busy before last", busy, 1'b1);
        check("a5 full before last", full, 1'b0);
        check("a5 no early valid", vcnt, 0);
        send_bit(w[0], 1'b0, 1'b0, 1'b0);
        check("a5 dout", dout, 8'hA5);
        check("a5 full", full, 1'b1);
        check("a5 valid", valid, 1'b1);
        check("a5 busy after", busy, 1'b0);
        check("a5 ovr", ovr, 1'b0);
        check("a5 ferr", ferr, 1'b0);
        tick();
        check("a5 valid one cycle", valid, 1'b0);
        check("a5 valid count", vcnt, 1);

        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("rd clears full", full, 1'b0);
        check("rd keeps dout", dout, 8'hA5);

        // Continuous stream, table-driven
        for (int k = 0; k < 5; k++) begin
            send_word(tbl[k].word, tbl[k].sync_first, tbl[k].rd_first, tbl[k].rd_last, tbl[k].clr_first);
            check($sformatf("row%0d dout", k), dout, tbl[k].exp_dout);
            check($sformatf("row%0d full", k), full, tbl[k].exp_full);
            check($sformatf("row%0d valid", k), valid, tbl[k].exp_valid);
            check($sformatf("row%0d ovr", k), ovr, tbl[k].exp_ovr);
            check($sformatf("row%0d ferr", k), ferr, tbl[k].exp_ferr);
        end
        tick();
        check("stream valid count", vcnt, 5);

        // Framing error: 3 bits, then sync mid-word, then 0x5A
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("pre-frame full", full, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        check("fragment busy", busy, 1'b1);
        check("fragment ferr", ferr, 1'b0);
        w = 8'h5A;
        send_bit(w[7], 1'b1, 1'b0, 1'b0);
        check("mid sync ferr", ferr, 1'b1);
        check("mid sync full", full, 1'b0);
        for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0, 1'b0, 1'b0);
        check("5a dout", dout, 8'h5A);
        check("5a valid", valid, 1'b1);
        check("5a ferr sticky", ferr, 1'b1);
        tick();
        check("5a valid count", vcnt, 6);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err ferr", ferr, 1'b0);

        // Set beats clear on the same edge
        send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0, 1'b1);
        check("ferr set wins clr", ferr, 1'b1);

        // Reset after 5 bits of a word
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre-reset busy", busy, 1'b1);
        check("pre-reset full", full, 1'b1);
        n_clr = 1'b0;
        #1;
        check("async dout", dout, 8'h00);
        check("async dout lsb", dout_lsb, 8'h00);
        check("async full", full, 1'b0);
        check("async busy", busy, 1'b0);
        check("async ferr", ferr, 1'b0);
        check("async ovr", ovr, 1'b0);
        repeat (2) tick();
        n_clr = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        check("no sync full", full, 1'b0);
        check("no sync busy", busy, 1'b0);
        check("no sync dout", dout, 8'h00);
        tick();
        check("no sync valid count", vcnt, 6);

        // Bit order: 1,0,0,0,0,0,0,0
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        check("lsb-first dout", dout_lsb, 8'h01);
        check("lsb-first valid", valid_lsb, 1'b1);
        check("lsb-first full", full_lsb, 1'b1);
        check("msb-first dout", dout, 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
